timing_engine_ctrl: RTL and testbench

// - Driving end of the timing-engine handshake: sequences PLL power-up, settle and RX enable for the radio.
// - Drives pllSettled/tArstFs toward the radio sync flops; watches their registered echoes radioEnableSynced/radioRxEnSynced.
// - Flags lock-loss and echo timeouts. Sits between the PLL macro and the radio timing/sync logic, single clock domain ck.

---
 rtl/timing_engine_pkg.sv | 32 +++
 rtl/te_sat_counter.sv | 28 ++
 rtl/timing_engine_ctrl.sv | 138 +++++++++++++
 tb/tb_timing_engine_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/timing_engine_pkg.sv
// rtl/timing_engine_pkg.sv - shared state/error types and default timing for the timing-engine controller
package timing_engine_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_WAIT  = 3'd1,
    SETTLE    = 3'd2,
    SYNC_WAIT = 3'd3,
    ACTIVE    = 3'd4,
    SHUTDOWN  = 3'd5,
    ERROR     = 3'd6
  } te_state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_LOCK_TIMEOUT = 2'd1,
    ERR_LOCK_LOST    = 2'd2,
    ERR_ECHO_TIMEOUT = 2'd3
  } te_err_e;

  localparam int DEF_LOCK_TIMEOUT_CYC = 256;
  localparam int DEF_SETTLE_CYC       = 64;
  localparam int DEF_ACK_TIMEOUT_CYC  = 16;

  // Largest of three cycle limits; sizes the shared counter width.
  function automatic int te_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/te_sat_counter.sv
// rtl/te_sat_counter.sv - saturating cycle counter with terminal-count compare
module te_sat_counter #(
  parameter int CNT_W = 9
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] count;

  // Count up while enabled, stick at all-ones so a long dwell never wraps back into range.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/timing_engine_ctrl.sv
// rtl/timing_engine_ctrl.sv - PLL power-up, settle and RX-enable sequencer toward the radio sync flops
module timing_engine_ctrl
  import timing_engine_pkg::*;
#(
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int SETTLE_CYC       = DEF_SETTLE_CYC,
  parameter int ACK_TIMEOUT_CYC  = DEF_ACK_TIMEOUT_CYC
) (
  input  logic       ck,
  input  logic       arst,
  input  logic       radio_on_req,
  input  logic       rx_mode,
  input  logic       pll_lock,
  input  logic       radioEnableSynced,
  input  logic       radioRxEnSynced,
  output logic       pll_en,
  output logic       pllSettled,
  output logic       tArstFs,
  output logic       ready,
  output logic [1:0] err_code,
  output logic [2:0] state_o
);

  localparam int CNT_W = $clog2(te_max3(LOCK_TIMEOUT_CYC, SETTLE_CYC, ACK_TIMEOUT_CYC)) + 1;

  te_state_e        state, next_state;
  te_err_e          next_err;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_hit, mis_hit;
  logic             state_chg, mismatch, mis_clear;

  assign state_chg = (next_state != state);
  assign mismatch  = (radioRxEnSynced != tArstFs);
  assign mis_clear = state_chg || !mismatch || (state != ACTIVE);
  assign state_o   = state;

  // Dwell limit for the state-time counter depends on which wait we are in.
  always_comb begin
    cnt_term = CNT_W'(ACK_TIMEOUT_CYC - 1);
    if (state == PLL_WAIT) cnt_term = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    else if (state == SETTLE) cnt_term = CNT_W'(SETTLE_CYC - 1);
  end

  te_sat_counter #(.CNT_W(CNT_W)) u_state_cnt (
    .ck     (ck),
    .arst   (arst),
    .clear  (state_chg),
    .enable (1'b1),
    .term   (cnt_term),
    .hit    (cnt_hit)
  );

  te_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
    .ck     (ck),
    .arst   (arst),
    .clear  (mis_clear),
    .enable (mismatch),
    .term   (CNT_W'(ACK_TIMEOUT_CYC - 1)),
    .hit    (mis_hit)
  );

  // Next state and error cause; request drop beats lock loss beats echo timeout.
  always_comb begin
    next_state = state;
    next_err   = ERR_NONE;
    case (state)
      IDLE: begin
        if (radio_on_req) next_state = PLL_WAIT;
      end
      PLL_WAIT: begin
        if (!radio_on_req) next_state = IDLE;
        else if (pll_lock) next_state = SETTLE;
        else if (cnt_hit) begin
          next_state = ERROR;
          next_err   = ERR_LOCK_TIMEOUT;
        end
      end
      SETTLE: begin
        if (!radio_on_req) next_state = IDLE;
        else if (!pll_lock) next_state = PLL_WAIT;
        else if (cnt_hit) next_state = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (!radio_on_req) next_state = SHUTDOWN;
        else if (!pll_lock) begin
          next_state = ERROR;
          next_err   = ERR_LOCK_LOST;
        end else if (radioEnableSynced) next_state = ACTIVE;
        else if (cnt_hit) begin
          next_state = ERROR;
          next_err   = ERR_ECHO_TIMEOUT;
        end
      end
      ACTIVE: begin
        if (!radio_on_req) next_state = SHUTDOWN;
        else if (!pll_lock) begin
          next_state = ERROR;
          next_err   = ERR_LOCK_LOST;
        end else if (!radioEnableSynced || (mismatch && mis_hit)) begin
          next_state = ERROR;
          next_err   = ERR_ECHO_TIMEOUT;
        end
      end
      SHUTDOWN: begin
        if (!radioEnableSynced && !radioRxEnSynced) next_state = IDLE;
        else if (cnt_hit) begin
          next_state = ERROR;
          next_err   = ERR_ECHO_TIMEOUT;
        end
      end
      ERROR: begin
        if (!radio_on_req) next_state = IDLE;
        else next_err = te_err_e'(err_code);
      end
      default: next_state = IDLE;
    endcase
  end

  // State and outputs registered together; outputs decode the next state so they line up with it.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      pll_en     <= 1'b0;
      pllSettled <= 1'b0;
      tArstFs    <= 1'b0;
      ready      <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= next_state;
      pll_en     <= (next_state != IDLE) && (next_state != ERROR);
      pllSettled <= (next_state == SYNC_WAIT) || (next_state == ACTIVE);
      tArstFs    <= (next_state == ACTIVE) && rx_mode;
      ready      <= (next_state == ACTIVE);
      err_code   <= (next_state == ERROR) ? next_err : 2'd0;
    end
  end

endmodule

// File: tb/tb_timing_engine_ctrl.sv
// tb/tb_timing_engine_ctrl.sv - self-checking bench for timing_engine_ctrl
module tb_timing_engine_ctrl;

  localparam int S_IDLE = 0, S_PW = 1, S_SET = 2, S_SYNC = 3, S_ACT = 4, S_SD = 5, S_ERR = 6;

  logic       ck = 1'b0;
  logic       arst = 1'b1;
  logic       radio_on_req = 1'b0, rx_mode = 1'b0, pll_lock = 1'b0;
  logic       radioEnableSynced = 1'b0, radioRxEnSynced = 1'b0;
  logic       pll_en, pllSettled, tArstFs, ready;
  logic [1:0] err_code;
  logic [2:0] state_o;
  bit         echo_off = 1'b0, rx_stuck = 1'b0;
  int         cyc = 0, n_chk = 0, n_fail = 0;

  typedef struct {
    string nm; int due; int st; bit pe; bit ps; bit ta; bit rd; int err;
  } exp_t;

  typedef struct {
    string nm; bit req; bit lock; bit rx; bit eoff; bit stk; int n;
    int st; bit pe; bit ps; bit ta; bit rd; int err;
  } vec_t;

  exp_t sbq[$];

  timing_engine_ctrl dut (
    .ck                (ck),
    .arst              (arst),
    .radio_on_req      (radio_on_req),
    .rx_mode           (rx_mode),
    .pll_lock          (pll_lock),
    .radioEnableSynced (radioEnableSynced),
    .radioRxEnSynced   (radioRxEnSynced),
    .pll_en            (pll_en),
    .pllSettled        (pllSettled),
    .tArstFs           (tArstFs),
    .ready             (ready),
    .err_code          (err_code),
    .state_o           (state_o)
  );

  always #5 ck = ~ck;

  // Radio side: one-cycle registered echoes, with knobs to disconnect or stick them.
  always @(posedge ck) begin
    cyc               <= cyc + 1;
    radioEnableSynced <= echo_off ? 1'b0 : pllSettled;
    radioRxEnSynced   <= rx_stuck ? 1'b0 : tArstFs;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic expect_now(input string nm, input int st, input bit pe, input bit ps,
                            input bit ta, input bit rd, input int err);
    exp_t e;
    e = '{nm, cyc, st, pe, ps, ta, rd, err};
    sbq.push_back(e);
  endtask

  function automatic vec_t mk(input string nm, input bit req, input bit lock, input bit rx,
                              input bit eoff, input bit stk, input int n, input int st,
                              input bit pe, input bit ps, input bit ta, input bit rd,
                              input int err);
    vec_t v;
    v = '{nm, req, lock, rx, eoff, stk, n, st, pe, ps, ta, rd, err};
    return v;
  endfunction

  // Scoreboard: compare every expectation that has come due against the sampled outputs.
  always @(negedge ck) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.nm, ".state"},      int'(state_o),    e.st);
      chk({e.nm, ".pll_en"},     int'(pll_en),     int'(e.pe));
      chk({e.nm, ".pllSettled"}, int'(pllSettled), int'(e.ps));
      chk({e.nm, ".tArstFs"},    int'(tArstFs),    int'(e.ta));
      chk({e.nm, ".ready"},      int'(ready),      int'(e.rd));
      chk({e.nm, ".err_code"},   int'(err_code),   e.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    //                  name             req lk rx eo st  n    state  pe ps ta rd err
    vt.push_back(mk("req_rise",          1, 0, 0, 0, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("pll_wait_hold",     1, 0, 0, 0, 0,   3, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("lock_to_settle",    1, 1, 0, 0, 0,   1, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("settle_hold",       1, 1, 0, 0, 0,  63, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("settled",           1, 1, 0, 0, 0,   1, S_SYNC, 1, 1, 0, 0, 0));
    vt.push_back(mk("echo_wait",         1, 1, 0, 0, 0,   1, S_SYNC, 1, 1, 0, 0, 0));
    vt.push_back(mk("active",            1, 1, 0, 0, 0,   1, S_ACT,  1, 1, 0, 1, 0));
    vt.push_back(mk("rx_on",             1, 1, 1, 0, 0,   1, S_ACT,  1, 1, 1, 1, 0));
    vt.push_back(mk("rx_off",            1, 1, 0, 0, 0,   1, S_ACT,  1, 1, 0, 1, 0));
    vt.push_back(mk("rx_on2",            1, 1, 1, 0, 0,   3, S_ACT,  1, 1, 1, 1, 0));
    vt.push_back(mk("rx_stuck_hold",     1, 1, 1, 0, 1,  16, S_ACT,  1, 1, 1, 1, 0));
    vt.push_back(mk("rx_stuck_err",      1, 1, 1, 0, 1,   1, S_ERR,  0, 0, 0, 0, 3));
    vt.push_back(mk("err_held",          1, 1, 1, 0, 1,   2, S_ERR,  0, 0, 0, 0, 3));
    vt.push_back(mk("err_clear",         0, 1, 0, 0, 0,   1, S_IDLE, 0, 0, 0, 0, 0));
    vt.push_back(mk("lt_req",            1, 0, 0, 0, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("lt_hold",           1, 0, 0, 0, 0, 255, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("lt_err",            1, 0, 0, 0, 0,   1, S_ERR,  0, 0, 0, 0, 1));
    vt.push_back(mk("lt_clear",          0, 0, 0, 0, 0,   1, S_IDLE, 0, 0, 0, 0, 0));
    vt.push_back(mk("gl_req",            1, 1, 0, 1, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("gl_settle",         1, 1, 0, 1, 0,   1, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("gl_settle30",       1, 1, 0, 1, 0,  29, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("gl_drop",           1, 0, 0, 1, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("gl_relock",         1, 1, 0, 1, 0,   1, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("gl_settle_hold",    1, 1, 0, 1, 0,  63, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("gl_settled",        1, 1, 0, 1, 0,   1, S_SYNC, 1, 1, 0, 0, 0));
    vt.push_back(mk("noecho_hold",       1, 1, 0, 1, 0,  15, S_SYNC, 1, 1, 0, 0, 0));
    vt.push_back(mk("noecho_err",        1, 1, 0, 1, 0,   1, S_ERR,  0, 0, 0, 0, 3));
    vt.push_back(mk("noecho_clear",      0, 1, 0, 0, 0,   1, S_IDLE, 0, 0, 0, 0, 0));
    vt.push_back(mk("sd_req",            1, 1, 0, 0, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("sd_settle",         1, 1, 0, 0, 0,   1, S_SET,  1, 0, 0, 0, 0));
    vt.push_back(mk("sd_sync",           1, 1, 0, 0, 0,  64, S_SYNC, 1, 1, 0, 0, 0));
    vt.push_back(mk("sd_active",         1, 1, 0, 0, 0,   2, S_ACT,  1, 1, 0, 1, 0));
    vt.push_back(mk("sd_drop_req_lock",  0, 0, 0, 0, 0,   1, S_SD,   1, 0, 0, 0, 0));
    vt.push_back(mk("sd_req_ignored",    1, 0, 0, 0, 0,   1, S_SD,   1, 0, 0, 0, 0));
    vt.push_back(mk("sd_idle",           1, 0, 0, 0, 0,   1, S_IDLE, 0, 0, 0, 0, 0));
    vt.push_back(mk("sd_rereq",          1, 0, 0, 0, 0,   1, S_PW,   1, 0, 0, 0, 0));
    vt.push_back(mk("final_idle",        0, 0, 0, 0, 0,   1, S_IDLE, 0, 0, 0, 0, 0));

    // Reset state, with request already asserted to show reset dominates.
    radio_on_req = 1'b1;
    repeat (2) tick();
    expect_now("reset", S_IDLE, 0, 0, 0, 0, 0);
    @(negedge ck);
    radio_on_req = 1'b0;
    arst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      radio_on_req = vt[i].req;
      pll_lock     = vt[i].lock;
      rx_mode      = vt[i].rx;
      echo_off     = vt[i].eoff;
      rx_stuck     = vt[i].stk;
      repeat (vt[i].n) tick();
      expect_now(vt[i].nm, vt[i].st, vt[i].pe, vt[i].ps, vt[i].ta, vt[i].rd, vt[i].err);
    end

    // Asynchronous reset in the middle of SETTLE, then restart from IDLE on release.
    radio_on_req = 1'b1;
    pll_lock     = 1'b1;
    tick();
    tick();
    expect_now("ar_settle", S_SET, 1, 0, 0, 0, 0);
    repeat (10) tick();
    #1 arst = 1'b1;
    expect_now("ar_async", S_IDLE, 0, 0, 0, 0, 0);
    tick();
    expect_now("ar_held", S_IDLE, 0, 0, 0, 0, 0);
    @(negedge ck);
    arst = 1'b0;
    tick();
    expect_now("ar_restart", S_PW, 1, 0, 0, 0, 0);

    // Lock loss while ACTIVE with request still up.
    for (int i = 0; i < 100 && state_o != 3'(S_ACT); i++) tick();
    chk("reach_active", int'(state_o), S_ACT);
    pll_lock = 1'b0;
    tick();
    expect_now("active_lock_lost", S_ERR, 0, 0, 0, 0, 2);
    radio_on_req = 1'b0;
    tick();
    expect_now("lock_lost_clear", S_IDLE, 0, 0, 0, 0, 0);

    @(negedge ck);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
